latch_array_ctrl: RTL
=====================

# latch_array_ctrl

Sequencer and two-port arbiter for the latch-based storage array built from gated D-latch cells (NAND SR latch with write enable). It takes word-level read/write requests from two masters, picks one round-robin, and drives the array's per-row write-enable and read-enable strobes. Because the cells are level-sensitive, it brackets each strobe with dedicated setup and hold cycles. It sits between the bus-side masters and the raw cell array.

## Interface
- WIDTH, 8, data bits per word (cells per row)
- DEPTH, 16, rows in the array; AW = $clog2(DEPTH) is derived, not overridable
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request present, bit i = port i
- req_write  in  2  1 = write, 0 = read, per port
- req_addr  in  2*AW  row address, port i in bits [i*AW +: AW]
- req_wdata  in  2*WIDTH  write data, port i in bits [i*WIDTH +: WIDTH]
- req_ready  out  2  grant; transfer occurs when valid[i] & ready[i]
- rsp_valid  out  2  one-cycle completion pulse for port i
- rsp_rdata  out  WIDTH  read data, valid only with rsp_valid of a read
- arr_we  out  DEPTH  one-hot row write-enable to cell array
- arr_re  out  DEPTH  one-hot row read-enable to cell array
- arr_wdata  out  WIDTH  data bus to cell data inputs
- arr_rdata  in  WIDTH  data bus from the selected row (combinational from array)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD; reset state IDLE.
- IDLE:
  - req_ready is combinational: at most one bit set, and only if its req_valid is high.
  - On transfer, latch the port id, write flag, address and data into command registers, then go to SETUP.
- SETUP: arr_wdata = command data (writes only; unchanged for reads); all strobes low. Go to STROBE.
- STROBE:
  - Write: arr_we[addr] = 1.
  - Read: arr_re[addr] = 1, and arr_rdata is registered into rsp_rdata at the end of this cycle.
  - Go to HOLD.
- HOLD: strobes low; arr_wdata unchanged; rsp_valid[port] = 1 for this cycle, for both reads and writes. Go to IDLE.
- arr_wdata and rsp_rdata are registers that hold their value until the next write or read overwrites them.
- Arbitration:
  - A last-grant pointer holds the port most recently granted; its reset value is 1, so port 0 wins first.
  - When both ports are valid, grant the port not equal to last-grant. When one is valid, grant it.
  - The pointer updates only on a transfer.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not a power of two):
  - The request is accepted and sequenced normally, but no strobe bit is set.
  - A read returns all zeros; rsp_valid still fires.
- At most one bit of arr_we | arr_re is ever high. arr_we and arr_re are never high in the same cycle.
- req_ready is 0 in every state other than IDLE. A master holds its valid and payload until ready.

## Timing
- Write latency: transfer in cycle n; arr_wdata is valid from n+1; arr_we is high in n+2 only; rsp_valid in n+3; the next transfer can occur in n+4.
- Read latency: transfer in n; arr_re is high in n+2; rsp_valid and rsp_rdata are valid in n+3.
- Throughput: one operation per 4 cycles, regardless of port.
- Setup and hold: arr_wdata is stable 1 cycle before, during, and 1 cycle after the arr_we pulse.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, arr_we 0, arr_re 0, arr_wdata 0, last-grant 1, state IDLE.
- Reset mid-operation:
  - All strobes drop asynchronously and the in-flight operation is discarded with no rsp_valid.
  - A partially written row is undefined from the array's side; the controller makes no guarantee.
- A req_valid deasserting in IDLE without a transfer has no effect. Asserting it during SETUP, STROBE or HOLD waits for IDLE.

## Structure
- Package latch_array_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD);
  - the command struct (port, write, addr, data), parameterised through localparams derived in the top module.
- Sub-module rr_arb2: a 2-requester round-robin arbiter with a last-grant register.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0], one-hot or zero.
  - Instantiated once.
- The row decoder (address to one-hot, gated by phase) stays inline in the top module.

## Test plan
- Single write then read, port 0: write addr 3 = 0xA5, then read addr 3. Required: arr_we = 0x0008 for exactly 1 cycle, and rsp_rdata = 0xA5 three cycles after the read transfer.
- Contention: both ports valid continuously, port 0 writes and port 1 reads. Required: grants alternate 0,1,0,1 starting with port 0, with transfers exactly 4 cycles apart.
- Setup/hold check: write 0xFF then 0x00 to row 5. Required: arr_wdata does not change in the cycle before, during, or after either arr_we pulse; a latch model reads back 0x00.
- Read of an untouched row against a latch model preset to 0x3C at row 15. Required: rsp_rdata = 0x3C and arr_re = 0x8000 only.
- Async reset asserted in STROBE of a write. Required: arr_we drops to 0 the same instant, no rsp_valid, and the first request after reset is granted to port 0.
- DEPTH = 12, read at addr 13. Required: no strobe bit set, rsp_valid pulses, rsp_rdata = 0.

Source files
------------

// File: rtl/latch_array_ctrl_pkg.sv
// Shared types for the latch array sequencer: phase enum and the latched command.
// Command fields are sized for the largest supported array (256 rows, 32-bit words).
package latch_array_ctrl_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  port;
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant register favours the other port on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

  // Reset to port 1 so that port 0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= 1'b1;
    else if (advance) last <= gnt[1];
  end

endmodule

// File: rtl/latch_array_ctrl.sv
// Two-port sequencer for a level-sensitive latch array: arbitrates, then runs
// SETUP / STROBE / HOLD so data is stable around every row strobe.
module latch_array_ctrl
  import latch_array_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_write,
  input  logic [2*AW-1:0]    req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic [DEPTH-1:0]   arr_we,
  output logic [DEPTH-1:0]   arr_re,
  output logic [WIDTH-1:0]   arr_wdata,
  input  logic [WIDTH-1:0]   arr_rdata
);

  state_t                state, state_nxt;
  cmd_t                  cmd;
  logic [1:0]            gnt;
  logic                  transfer;
  logic                  gport;
  logic [CMD_ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic                  in_range;
  logic [DEPTH-1:0]      row_sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ((state == IDLE) ? req_valid : 2'b00),
    .advance (transfer),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign transfer  = |gnt;
  assign gport     = gnt[1];
  assign sel_addr  = CMD_ADDR_W'(gport ? req_addr[2*AW-1:AW] : req_addr[AW-1:0]);
  assign sel_wdata = gport ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];

  // Rows past DEPTH still get sequenced, they just never see a strobe.
  assign in_range  = (cmd.addr < CMD_ADDR_W'(DEPTH));

  always_comb begin
    row_sel = '0;
    if (in_range) row_sel[cmd.addr[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arr_we    = '0;
    arr_re    = '0;
    rsp_valid = 2'b00;
    case (state)
      IDLE:   if (transfer) state_nxt = SETUP;
      SETUP:  state_nxt = STROBE;
      STROBE: begin
        if (cmd.write) arr_we = row_sel;
        else           arr_re = row_sel;
        state_nxt = HOLD;
      end
      HOLD: begin
        rsp_valid = cmd.port ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write data is captured at the transfer so it is already on the bus during SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (transfer) begin
      cmd.port  <= gport;
      cmd.write <= req_write[gport];
      cmd.addr  <= sel_addr;
      if (req_write[gport]) cmd.data <= CMD_DATA_W'(sel_wdata);
    end
  end

  assign arr_wdata = cmd.data[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_rdata <= '0;
    else if (state == STROBE && !cmd.write)
      rsp_rdata <= in_range ? arr_rdata : '0;
  end

endmodule
